// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - Moore serial-pattern detector with KMP matching, ack handshake and saturating hit count
module seq_detector_param #(
  parameter int              PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             en,
  input  logic             cntrl,
  input  logic             ovl,
  output logic             w,
  output logic             i0,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int KW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  typedef enum logic {S_MATCH = 1'b0, S_HOLD = 1'b1} state_t;

  // Longest suffix of (top k pattern bits, b) that is also a pattern prefix.
  function automatic int kmp_len(input int k, input logic b);
    int   res;
    int   idx;
    logic ok;
    logic sb;
    res = 0;
    for (int len = 1; len <= PAT_W; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < PAT_W; t++) begin
          if (t < len) begin
            idx = k + 1 - len + t;
            sb  = (idx < k) ? PATTERN[PAT_W-1-idx] : b;
            if (sb != PATTERN[PAT_W-1-t]) ok = 1'b0;
          end
        end
        if (ok) res = len;
      end
    end
    return res;
  endfunction

  function automatic int border_len();
    int   res;
    logic ok;
    res = 0;
    for (int len = 1; len < PAT_W; len++) begin
      ok = 1'b1;
      for (int t = 0; t < PAT_W; t++) begin
        if (t < len && PATTERN[len-1-t] != PATTERN[PAT_W-1-t]) ok = 1'b0;
      end
      if (ok) res = len;
    end
    return res;
  endfunction

  localparam int BORDER = border_len();

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            cnt_inc;
  int              len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_MATCH;
      k       <= '0;
      hit_cnt <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (cnt_inc) hit_cnt <= hit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_inc   = 1'b0;
    len       = 0;
    case (state)
      S_MATCH: begin
        if (en) begin
          len = kmp_len(int'(k), j);
          if (len == PAT_W) begin
            state_nxt = S_HOLD;
            k_nxt     = '0;
            cnt_inc   = (hit_cnt != {CNT_W{1'b1}});
          end else begin
            k_nxt = KW'(len);
          end
        end
      end
      S_HOLD: begin
        if (cntrl) begin
          state_nxt = S_MATCH;
          k_nxt     = ovl ? KW'(BORDER) : '0;
        end
      end
      default: begin
        state_nxt = S_MATCH;
        k_nxt     = '0;
      end
    endcase
  end

  assign w  = (state == S_HOLD);
  assign i0 = (state == S_MATCH) && (k == KW'(PAT_W - 1));

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, j, en, cntrl, ovl;
  logic       w, i0, w2, i02;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt2;
  int         checks   = 0;
  int         failures = 0;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .j(j), .en(en), .cntrl(cntrl), .ovl(ovl),
    .w(w), .i0(i0), .hit_cnt(hit_cnt)
  );

  // Narrow counter copy shares the stimulus; only its count differs.
  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .j(j), .en(en), .cntrl(cntrl), .ovl(ovl),
    .w(w2), .i0(i02), .hit_cnt(hit_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic jv, input logic env);
    j  = jv;
    en = env;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pat();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1); step(0, 1);
  endtask

  initial begin
    rst = 1; j = 1; en = 1; cntrl = 1; ovl = 0;
    step(1, 1);
    step(1, 1);
    chk("reset_w", w, 0);
    chk("reset_i0", i0, 0);
    chk("reset_hit", hit_cnt, 0);

    rst = 0; cntrl = 0;
    step(1, 1); chk("basic_i0_1", i0, 0);
    step(0, 1); chk("basic_i0_2", i0, 0);
    step(1, 1); chk("basic_i0_3", i0, 0);
    step(1, 1); chk("basic_i0_4", i0, 1); chk("basic_w_4", w, 0);
    step(0, 1); chk("basic_i0_5", i0, 0); chk("basic_w_5", w, 1);
    chk("basic_hit", hit_cnt, 1);
    for (int c = 0; c < 3; c++) begin
      step(c[0], 1);
      chk("hold_w", w, 1);
      chk("hold_hit", hit_cnt, 1);
    end
    cntrl = 1;
    step(1, 1); chk("ack_w", w, 0); chk("ack_k", dut.k, 0);
    cntrl = 0;

    step(1, 1); chk("kmp_k1", dut.k, 1);
    step(0, 1); chk("kmp_k2", dut.k, 2);
    step(1, 1); chk("kmp_k3", dut.k, 3);
    step(0, 1); chk("kmp_k4", dut.k, 2);
    step(1, 1); chk("kmp_k5", dut.k, 3);
    step(1, 1); chk("kmp_k6", dut.k, 4); chk("kmp_i0_6", i0, 1);
    step(0, 1); chk("kmp_w7", w, 1); chk("kmp_hit", hit_cnt, 2);

    cntrl = 1; ovl = 1;
    step(0, 1); chk("ovl_ack_w", w, 0); chk("ovl_ack_k", dut.k, 2);
    cntrl = 0; ovl = 0;
    step(1, 1); chk("ovl_k3", dut.k, 3);
    step(1, 1); chk("ovl_i0", i0, 1);
    step(0, 1); chk("ovl_w", w, 1); chk("ovl_hit", hit_cnt, 3);

    cntrl = 1; ovl = 0;
    step(1, 1); chk("novl_ack_k", dut.k, 0);
    cntrl = 0;
    step(1, 1); step(1, 1);
    step(0, 1); chk("novl_no_match", w, 0); chk("novl_k", dut.k, 2);
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    chk("novl_w_pre", w, 0);
    step(0, 1); chk("novl_w", w, 1); chk("novl_hit", hit_cnt, 4);

    cntrl = 1;
    step(0, 1);
    cntrl = 0;
    step(1, 1); chk("en_k1", dut.k, 1);
    step(0, 0); chk("en_hold_k", dut.k, 1);
    step(0, 1); step(1, 0); step(1, 1); step(0, 0); step(1, 1); step(1, 0);
    chk("en_w_pre", w, 0); chk("en_i0_pre", i0, 1);
    step(0, 1); chk("en_w", w, 1); chk("en_hit", hit_cnt, 5);

    rst = 1;
    step(0, 1);
    rst = 0; cntrl = 1; ovl = 0;
    for (int m = 0; m < 5; m++) begin
      send_pat();
      chk("sat_w", w, 1);
      chk("sat_w2", w2, 1);
      chk("sat_hit2", hit_cnt2, (m + 1 > 3) ? 3 : m + 1);
      chk("sat_hit", hit_cnt, m + 1);
      step(1, 1);
      chk("sat_ack_w", w, 0);
    end

    cntrl = 0;
    send_pat();
    chk("mid_pre_w", w, 1);
    rst = 1;
    step(1, 1);
    chk("mid_rst_w", w, 0);
    chk("mid_rst_hit", hit_cnt, 0);
    chk("mid_rst_i0", i0, 0);
    rst = 0;
    send_pat();
    chk("post_rst_w", w, 1);
    chk("post_rst_hit", hit_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
